tnn_sample_sequencer: RTL and testbench
=======================================

Name: tnn_sample_sequencer

Overview:
- Front-end controller for the evolved 2-bit-feature TNN classifier cores: 6 features x 2 bits in, 1-bit class out, purely combinational.
- Accepts a serial feature stream with a valid/ready handshake and assembles one sample per frame.
- Drives the external combinational core through a registered vector, captures its decision, and returns it on a result handshake.
- Keeps saturating statistics counters; detects framing errors and resynchronises after them.

Parameters:
- N_FEAT, 6, features per sample (core input count).
- FEAT_W, 2, bits per feature.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- feat_valid  in  1  feature word valid.
- feat_ready  out  1  sequencer can accept a feature.
- feat_data  in  FEAT_W  feature value.
- feat_last  in  1  marks final feature of a frame.
- core_vec  out  N_FEAT*FEAT_W  registered sample to core; feature k at bits [FEAT_W*k +: FEAT_W], so feature 0 maps to core input a.
- core_out  in  1  combinational core decision.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_class  out  1  captured class, 0 on error.
- res_err  out  1  frame had a framing error.
- clr_cnt  in  1  synchronous counter clear.
- cnt_total  out  CNT_W  good results delivered.
- cnt_pos  out  CNT_W  good results delivered with class 1.

Behaviour:
- Reset values: state=COLLECT, idx=0, core_vec=0, res_valid=0, res_class=0, res_err=0, cnt_total=0, cnt_pos=0. Reset mid-frame discards the partial sample and any pending result.
- States: COLLECT, DRAIN, EVAL, HOLD.
- feat_ready=1 only in COLLECT and DRAIN. A transfer happens when feat_valid & feat_ready.
- COLLECT, on transfer: write feat_data into slot idx of core_vec.
  - idx==N_FEAT-1 & feat_last: go to EVAL, idx=0.
  - idx<N_FEAT-1 & !feat_last: idx+1, stay in COLLECT.
  - idx<N_FEAT-1 & feat_last (short frame): set err, go to HOLD, idx=0.
  - idx==N_FEAT-1 & !feat_last (long frame): set err, go to DRAIN.
- DRAIN: discard features until a transfer with feat_last, then go to HOLD. core_vec is unchanged.
- EVAL: one cycle. core_vec is stable since the previous edge. res_class<=core_out. Go to HOLD.
- HOLD: res_valid=1. res_class and res_err are held stable until res_ready.
  - On res_valid & res_ready: go to COLLECT, clear err. No new feature is accepted in that cycle.
  - If err is set, res_class=0.
- Latency: last feature accepted at edge T; EVAL during cycle T+1; res_valid high from T+2.
- Throughput: N_FEAT+2 cycles per sample with res_ready tied high.
- Counters update on a result handshake with res_err=0: cnt_total+1; cnt_pos+1 if res_class=1.
  - Both saturate at all-ones (no wrap).
  - clr_cnt has priority: counters go to 0 even when it coincides with a handshake.
- core_vec changes only on COLLECT transfers; a stale sample is held between frames.

Optional Feature:
- Macro: TNN_SEQ_EVAL2_EN.
- Defined: EVAL lasts 2 cycles and core_out is sampled at the end of the second. This gives a two-cycle multicycle path for large cores. Latency becomes res_valid from T+3; throughput N_FEAT+3.
- Undefined: single-cycle EVAL as above.

Test Plan:
- Bench core model: core_out = XOR-reduce(core_vec).
- Reset then stream 2,1,0,3,0,0 with last on the 6th -> core_vec=0x0C6; res_valid at T+2, res_class=0, res_err=0; cnt_total=1, cnt_pos=0.
- Stream 1,0,0,0,0,0 with res_ready low for 5 cycles -> res_valid held, res_class=1 stable, feat_ready=0 throughout; after handshake cnt_pos=1.
- Short frame: 3 features, last on the 3rd -> res_err=1, res_class=0, counters unchanged. Next good frame is classified correctly.
- Long frame: 8 features, last on the 8th -> feat_ready stays high through DRAIN; one result with res_err=1 after the 8th; core_vec holds the first 6 features.
- Preload cnt_total to all-ones by forcing or running; deliver a good result -> remains all-ones. Assert clr_cnt together with a handshake -> both counters 0.
- Assert rst for 1 cycle after the 4th feature -> all outputs return to reset values; a following full frame gives the correct result with idx starting at 0.

Source files
------------

// File: rtl/tnn_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tnn_sample_sequencer
//
// Front-end controller for a purely combinational TNN classifier core.
// A serial feature stream (valid/ready) is assembled into one sample per
// frame. The sample is presented to the core through a registered vector. The
// core decision is captured and returned on a result handshake. Saturating
// statistics count the good results.
//
// Framing errors are handled as follows:
//   - short frame (feat_last before N_FEAT features): an error result is
//     produced at once.
//   - long frame (no feat_last on the N_FEAT-th feature): the remaining
//     features are drained up to feat_last, then an error result is produced.
// An error result always carries res_class = 0. It is never counted.
//
// Optional build macro:
//   TNN_SEQ_EVAL2_EN - EVAL lasts two cycles, so the core path may take two
//                      clock periods (multicycle). Undefined: one-cycle EVAL.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   feat_valid/ready      feature stream handshake
//   feat_data, feat_last  feature value, end-of-frame marker
//   core_vec              registered sample; feature k at [FEAT_W*k +: FEAT_W]
//   core_out              combinational core decision
//   res_valid/ready       result handshake
//   res_class, res_err    captured class (0 on error), framing-error flag
//   clr_cnt               counter clear, wins over a coinciding result
//   cnt_total, cnt_pos    good results delivered / of those with class 1
// ---------------------------------------------------------------------------
module tnn_sample_sequencer #(
    parameter int N_FEAT = 6,
    parameter int FEAT_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [FEAT_W-1:0]          feat_data,
    input  logic                       feat_last,
    output logic [N_FEAT*FEAT_W-1:0]   core_vec,
    input  logic                       core_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_class,
    output logic                       res_err,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           cnt_total,
    output logic [CNT_W-1:0]           cnt_pos
);

    localparam int               IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DRAIN   = 2'd1,
        S_EVAL    = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    state_e                          state_q,     state_d;
    logic [IDX_W-1:0]                idx_q,       idx_d;
    logic [N_FEAT-1:0][FEAT_W-1:0]   vec_q,       vec_d;
    logic                            feat_ready_q, feat_ready_d;
    logic                            res_valid_q, res_valid_d;
    logic                            res_class_q, res_class_d;
    logic                            err_q,       err_d;
    logic [CNT_W-1:0]                cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0]                cnt_pos_q,   cnt_pos_d;
`ifdef TNN_SEQ_EVAL2_EN
    logic                            eval_cnt_q,  eval_cnt_d;
`endif

    logic feat_fire;
    logic res_fire;

    assign feat_fire = feat_valid & feat_ready_q;
    assign res_fire  = res_valid_q & res_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        res_class_d = res_class_q;
        err_d       = err_q;
        cnt_total_d = cnt_total_q;
        cnt_pos_d   = cnt_pos_q;
`ifdef TNN_SEQ_EVAL2_EN
        eval_cnt_d  = eval_cnt_q;
`endif

        unique case (state_q)
            S_COLLECT: begin
                if (feat_fire) begin
                    vec_d[idx_q] = feat_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (feat_last) begin
                            state_d = S_EVAL;
                        end else begin
                            // Long frame: sample is full, swallow the rest.
                            err_d       = 1'b1;
                            res_class_d = 1'b0;
                            state_d     = S_DRAIN;
                        end
                    end else if (feat_last) begin
                        // Short frame: report immediately, core is not consulted.
                        idx_d       = '0;
                        err_d       = 1'b1;
                        res_class_d = 1'b0;
                        state_d     = S_HOLD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (feat_fire && feat_last) begin
                    state_d = S_HOLD;
                end
            end

            S_EVAL: begin
`ifdef TNN_SEQ_EVAL2_EN
                // First cycle only lets the core settle; sample on the second.
                if (!eval_cnt_q) begin
                    eval_cnt_d = 1'b1;
                end else begin
                    eval_cnt_d  = 1'b0;
                    res_class_d = core_out;
                    state_d     = S_HOLD;
                end
`else
                res_class_d = core_out;
                state_d     = S_HOLD;
`endif
            end

            S_HOLD: begin
                if (res_fire) begin
                    err_d   = 1'b0;
                    state_d = S_COLLECT;
                end
            end

            default: state_d = S_COLLECT;
        endcase

        // Counters: clear wins over a coinciding good result.
        if (clr_cnt) begin
            cnt_total_d = '0;
            cnt_pos_d   = '0;
        end else if (res_fire && !err_q) begin
            if (cnt_total_q != CNT_MAX) cnt_total_d = cnt_total_q + CNT_W'(1);
            if (res_class_q && (cnt_pos_q != CNT_MAX)) cnt_pos_d = cnt_pos_q + CNT_W'(1);
        end

        // Handshake outputs follow the next state so they are plain flops.
        feat_ready_d = (state_d == S_COLLECT) || (state_d == S_DRAIN);
        res_valid_d  = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            idx_q        <= '0;
            vec_q        <= '0;
            feat_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_class_q  <= 1'b0;
            err_q        <= 1'b0;
            cnt_total_q  <= '0;
            cnt_pos_q    <= '0;
`ifdef TNN_SEQ_EVAL2_EN
            eval_cnt_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vec_q        <= vec_d;
            feat_ready_q <= feat_ready_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            err_q        <= err_d;
            cnt_total_q  <= cnt_total_d;
            cnt_pos_q    <= cnt_pos_d;
`ifdef TNN_SEQ_EVAL2_EN
            eval_cnt_q   <= eval_cnt_d;
`endif
        end
    end

    assign feat_ready = feat_ready_q;
    assign core_vec   = vec_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_err    = err_q;
    assign cnt_total  = cnt_total_q;
    assign cnt_pos    = cnt_pos_q;

endmodule

// File: tb/tb_tnn_sample_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for tnn_sample_sequencer. Counters are built 4 bits wide so that
// saturation is reached by running real frames. The core is modelled as the
// XOR-reduce of core_vec. Expected results come from a frame-level model:
// the sample is the first N_FEAT features of the frame, any length other than
// N_FEAT is an error, and counters saturate.
// ---------------------------------------------------------------------------
module tb_tnn_sample_sequencer;

    localparam int N_FEAT = 6;
    localparam int FEAT_W = 2;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;
`ifdef TNN_SEQ_EVAL2_EN
    localparam int EVAL_CYC = 2;
`else
    localparam int EVAL_CYC = 1;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      feat_valid = 1'b0;
    logic                      feat_ready;
    logic [FEAT_W-1:0]         feat_data = '0;
    logic                      feat_last = 1'b0;
    logic [N_FEAT*FEAT_W-1:0]  core_vec;
    logic                      core_out;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic                      res_class;
    logic                      res_err;
    logic                      clr_cnt = 1'b0;
    logic [CNT_W-1:0]          cnt_total;
    logic [CNT_W-1:0]          cnt_pos;

    assign core_out = ^core_vec;

    tnn_sample_sequencer #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .feat_last(feat_last),
        .core_vec(core_vec), .core_out(core_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_err(res_err),
        .clr_cnt(clr_cnt), .cnt_total(cnt_total), .cnt_pos(cnt_pos)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [N_FEAT*FEAT_W-1:0] m_vec = '0;
    logic                     m_cls = 1'b0;
    logic                     m_err = 1'b0;
    int                       m_total = 0;
    int                       m_pos = 0;
    logic [FEAT_W-1:0]        fq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame(input int len);
        fq.delete();
        repeat (len) fq.push_back(FEAT_W'($urandom_range(0, 3)));
    endtask

    // Frame-level view: first N_FEAT features land in the sample.
    task automatic model_frame();
        int len;
        len = fq.size();
        for (int i = 0; i < len && i < N_FEAT; i++) m_vec[FEAT_W*i +: FEAT_W] = fq[i];
        m_err = (len != N_FEAT);
        m_cls = m_err ? 1'b0 : ^m_vec;
    endtask

    // Called and returning on a negedge. Every feature must be accepted at once.
    task automatic send_frame(input bit give_last, input bit gaps);
        int stalls;
        stalls = 0;
        foreach (fq[i]) begin
            feat_valid = 1'b1;
            feat_data  = fq[i];
            feat_last  = give_last && (i == fq.size() - 1);
            for (int g = 0; g < 20 && !feat_ready; g++) begin
                stalls++;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            feat_valid = 1'b0;
            feat_last  = 1'b0;
            if (gaps && (i != fq.size() - 1) && ($urandom_range(0, 3) == 0)) @(negedge clk);
        end
        chk("feat_ready_stall", 32'(stalls), 32'(0));
    endtask

    task automatic take_result(input int hold, input bit clr);
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(m_err ? 0 : EVAL_CYC));
        chk("res_valid", 32'(res_valid), 32'(1));
        chk("res_class", 32'(res_class), 32'(m_cls));
        chk("res_err", 32'(res_err), 32'(m_err));
        chk("core_vec", 32'(core_vec), 32'(m_vec));
        // Offer a feature while holding; it must not be taken.
        feat_valid = 1'b1;
        feat_data  = 2'd3;
        feat_last  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'(1));
            chk("hold_class", 32'(res_class), 32'(m_cls));
            chk("hold_err", 32'(res_err), 32'(m_err));
            chk("hold_ready", 32'(feat_ready), 32'(0));
        end
        res_ready = 1'b1;
        clr_cnt   = clr;
        @(posedge clk);
        if (clr) begin
            m_total = 0;
            m_pos   = 0;
        end else if (!m_err) begin
            if (m_total < SAT) m_total++;
            if (m_cls && m_pos < SAT) m_pos++;
        end
        @(negedge clk);
        res_ready  = 1'b0;
        clr_cnt    = 1'b0;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        chk("post_valid", 32'(res_valid), 32'(0));
        chk("post_ready", 32'(feat_ready), 32'(1));
        chk("post_vec", 32'(core_vec), 32'(m_vec));
        chk("cnt_total", 32'(cnt_total), 32'(m_total));
        chk("cnt_pos", 32'(cnt_pos), 32'(m_pos));
    endtask

    task automatic do_frame(input int hold, input bit clr, input bit gaps);
        model_frame();
        send_frame(1'b1, gaps);
        take_result(hold, clr);
    endtask

    task automatic chk_reset_state();
        chk("rst_vec", 32'(core_vec), 32'(0));
        chk("rst_valid", 32'(res_valid), 32'(0));
        chk("rst_class", 32'(res_class), 32'(0));
        chk("rst_err", 32'(res_err), 32'(0));
        chk("rst_total", 32'(cnt_total), 32'(0));
        chk("rst_pos", 32'(cnt_pos), 32'(0));
        chk("rst_ready", 32'(feat_ready), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state();

        // Directed frame with known sample 0x0C6, class 0.
        fq = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
        do_frame(0, 1'b0, 1'b0);
        chk("vec_0c6", 32'(core_vec), 32'h0C6);
        chk("first_total", 32'(cnt_total), 32'(1));

        // Class 1 frame held for 5 cycles by the consumer.
        fq = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        do_frame(5, 1'b0, 1'b0);
        chk("first_pos", 32'(cnt_pos), 32'(1));

        // Short frame, then a good one.
        fq = '{2'd3, 2'd3, 2'd3};
        do_frame(2, 1'b0, 1'b0);
        rand_frame(N_FEAT);
        do_frame(1, 1'b0, 1'b0);

        // Long frame: drained, one error result, sample holds the first six.
        rand_frame(8);
        do_frame(0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_second_result", 32'(res_valid), 32'(0));
        end

        // Saturate cnt_total by running good frames, then one more.
        while (m_total < SAT) begin
            rand_frame(N_FEAT);
            do_frame(0, 1'b0, 1'b1);
        end
        fq = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        do_frame(0, 1'b0, 1'b0);
        chk("sat_total", 32'(cnt_total), 32'(SAT));

        // Clear coinciding with a good handshake.
        rand_frame(N_FEAT);
        do_frame(1, 1'b1, 1'b0);
        chk("clr_total", 32'(cnt_total), 32'(0));

        // Mid-frame reset after the 4th feature.
        rand_frame(N_FEAT);
        do_frame(0, 1'b0, 1'b0);
        rand_frame(4);
        send_frame(1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_vec   = '0;
        m_total = 0;
        m_pos   = 0;
        chk_reset_state();
        fq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
        do_frame(0, 1'b0, 1'b0);

        // Randomized frames: mostly well-formed, some short/long.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 9) < 7) ? N_FEAT : int'($urandom_range(1, 9));
            rand_frame(len);
            do_frame(int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
